pool_controller: RTL

Sequences one BIT_POOL instance for the Galois-oscillator TRNG.
- Arms the pool and waits for it to fill.
- Snapshots the pool and clears it for the next fill.
- Streams the snapshot out as OUT_WIDTH-bit words over a valid/ready handshake, repeating for a programmed number of pools.
- Sits between the bit pool and the host-side transport (UART/FIFO).

---
 rtl/pool_ctrl_pkg.sv | 23 ++
 rtl/pool_serializer.sv | 94 +++++++++
 rtl/pool_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pool_ctrl_pkg.sv
// Shared state type and sizing helpers for the bit-pool controller.
package pool_ctrl_pkg;

   // Controller states: wait for a request, arm the pool, stream the
   // snapshot out, then hold the pool cleared for one cycle before re-arming.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_CLEAR = 2'd3
   } ctrl_state_e;

   // Number of output words needed to carry one pool (ceiling division).
   function automatic int calc_nwords(input int pool_width, input int out_width);
      return (pool_width + out_width - 1) / out_width;
   endfunction

   // Width of the word index; a single-word pool still needs one bit.
   function automatic int calc_index_width(input int nwords);
      return (nwords > 1) ? $clog2(nwords) : 1;
   endfunction

endpackage

// File: rtl/pool_serializer.sv
// Holds a snapshot of the pool and streams it out LSB-word first over a
// valid/ready handshake. The final word is zero-padded above POOL_WIDTH.
module pool_serializer
   import pool_ctrl_pkg::*;
#(
   parameter int POOL_WIDTH = 100,
   parameter int OUT_WIDTH  = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic                  flush,
   input  logic [POOL_WIDTH-1:0] pool_data,
   input  logic                  dout_ready,
   output logic [OUT_WIDTH-1:0]  dout,
   output logic                  dout_valid,
   output logic                  last_accept
);

   localparam int NWORDS = calc_nwords(POOL_WIDTH, OUT_WIDTH);
   localparam int IDX_W  = calc_index_width(NWORDS);
   localparam int PAD_W  = NWORDS * OUT_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

   logic [PAD_W-1:0]     shadow_q;
   logic [PAD_W-1:0]     shadow_d;
   logic [IDX_W-1:0]     index_q;
   logic [IDX_W-1:0]     index_d;
   logic [OUT_WIDTH-1:0] dout_q;
   logic [OUT_WIDTH-1:0] dout_d;
   logic                 valid_q;
   logic                 valid_d;

   logic [PAD_W-1:0]     padded_data;
   logic [IDX_W-1:0]     index_next;
   logic                 accept;
   logic [OUT_WIDTH-1:0] shadow_words [NWORDS];

   // Slice the shadow register into output words so word k is addressable by index.
   for (genvar k = 0; k < NWORDS; k++) begin : g_words
      assign shadow_words[k] = shadow_q[k*OUT_WIDTH +: OUT_WIDTH];
   end

   assign accept      = valid_q & dout_ready;
   assign index_next  = index_q + 1'b1;
   assign last_accept = accept & (index_q == LAST_IDX);
   assign dout        = dout_q;
   assign dout_valid  = valid_q;

   // Zero-extend the incoming pool so bits at or above POOL_WIDTH read as 0.
   always_comb begin
      padded_data                  = '0;
      padded_data[POOL_WIDTH-1:0]  = pool_data;
   end

   // Snapshot on load, then step through the words as each one is accepted.
   always_comb begin
      shadow_d = shadow_q;
      index_d  = index_q;
      dout_d   = dout_q;
      valid_d  = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         shadow_d = padded_data;
         index_d  = '0;
         dout_d   = padded_data[OUT_WIDTH-1:0];
         valid_d  = 1'b1;
      end else if (accept) begin
         if (index_q == LAST_IDX) begin
            valid_d = 1'b0;
         end else begin
            index_d = index_next;
            dout_d  = shadow_words[index_next];
         end
      end
   end

   // Registered snapshot, index and output word so dout is glitch-free.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q <= '0;
         index_q  <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         index_q  <= index_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
      end
   end

endmodule

// File: rtl/pool_controller.sv
// Sequences one bit pool: arm it, wait for full, snapshot and stream the
// contents out, and repeat for the requested number of pools.
module pool_controller
   import pool_ctrl_pkg::*;
#(
   parameter int POOL_WIDTH  = 100,
   parameter int OUT_WIDTH   = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] n_pools,
   input  logic                   abort,
   input  logic                   pool_full,
   input  logic [POOL_WIDTH-1:0]  pool_data,
   output logic                   pool_enable,
   output logic [OUT_WIDTH-1:0]   dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] pools_done
);

   ctrl_state_e            state_q;
   ctrl_state_e            state_d;
   logic [COUNT_WIDTH-1:0] n_pools_q;
   logic [COUNT_WIDTH-1:0] n_pools_d;
   logic [COUNT_WIDTH-1:0] pools_done_q;
   logic [COUNT_WIDTH-1:0] pools_done_d;
   logic                   done_q;
   logic                   done_d;

   logic [COUNT_WIDTH-1:0] pools_inc;
   logic                   load;
   logic                   flush;
   logic                   last_accept;

   pool_serializer #(
      .POOL_WIDTH (POOL_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_serializer (
      .clock       (clock),
      .reset_n     (reset_n),
      .load        (load),
      .flush       (flush),
      .pool_data   (pool_data),
      .dout_ready  (dout_ready),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .last_accept (last_accept)
   );

   // Enable and busy decode straight from the registered state so they never glitch.
   assign pool_enable = (state_q == ST_FILL);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign pools_done  = pools_done_q;

   // Saturating increment: the completed-pool count sticks at all ones.
   assign pools_inc = (&pools_done_q) ? pools_done_q : pools_done_q + 1'b1;

   // Next-state logic; abort overrides everything, including a same-cycle start.
   always_comb begin
      state_d      = state_q;
      n_pools_d    = n_pools_q;
      pools_done_d = pools_done_q;
      done_d       = 1'b0;
      load         = 1'b0;
      flush        = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         flush   = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (n_pools != '0)) begin
                  n_pools_d    = n_pools;
                  pools_done_d = '0;
                  state_d      = ST_FILL;
               end
            end
            ST_FILL: begin
               if (pool_full) begin
                  load    = 1'b1;
                  state_d = ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_accept) begin
                  pools_done_d = pools_inc;
                  if (pools_inc == n_pools_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               state_d = ST_FILL;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, run length, progress counter and the done pulse register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         n_pools_q    <= '0;
         pools_done_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_pools_q    <= n_pools_d;
         pools_done_q <= pools_done_d;
         done_q       <= done_d;
      end
   end

endmodule
